sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous first-in/first-out buffer for the PE scratchpad input path. It accepts words from the upstream producer through a valid/ready handshake. It releases them downstream only while the drain-enable window from `fifo_flag_generator` is asserted. Storage depth is a power of two. Occupancy and status flags come straight from registered pointers, so no status output has a combinational path from any input.

## Interface
- `DATA_WIDTH`, 16, width of each stored word
- `ADDR_WIDTH`, 4, log2 of depth (DEPTH = 2^ADDR_WIDTH = 16)
- `AF_LEVEL`, 14, occupancy at or above which `almost_full` asserts (1..DEPTH)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  FIFO can accept a word
- `in_data`  in  DATA_WIDTH  write word
- `drain_en`  in  1  read window from `fifo_flag_generator`; that block updates on negedge, so this input is stable at posedge
- `out_valid`  out  1  head word available and reads permitted
- `out_ready`  in  1  consumer takes head word
- `out_data`  out  DATA_WIDTH  head word, first-word fall-through
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- `full`, `empty`, `almost_full`  out  1  status
- `overflow`  out  1  sticky error flag

## Operation
- `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits wide. The low bits address memory; the MSB is a wrap bit.
- Derived signals:
  - `count` = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1)
  - `empty` = (count == 0)
  - `full` = (count == DEPTH)
  - `almost_full` = (count ≥ AF_LEVEL)
- Handshake:
  - `in_ready` = !full && reset_n
  - push = in_valid && in_ready
  - `out_valid` = !empty && drain_en
  - pop = out_valid && out_ready
- Push writes `in_data` to mem[wr_ptr] and increments `wr_ptr`. Pop increments `rd_ptr`.
- `out_data` = mem[rd_ptr[ADDR_WIDTH-1:0]]. It is don't-care while `out_valid` is 0.
- Full and pop in the same cycle: the push is still refused, because `in_ready` does not depend on `out_ready`. The pop proceeds.
- Non-empty and non-full with push and pop in the same cycle: both occur and `count` is unchanged.
- Empty with push: no pop is possible that cycle.
- `drain_en` low blocks pops only. Pushes continue and the FIFO can fill while the window is closed.
- `overflow` sets when `in_valid && full`, i.e. the producer is stalled by a full FIFO. It stays set until `clear` or reset.
- `clear` takes priority over push and pop in the same cycle. It zeroes both pointers and `overflow`; memory contents are not cleared.
- Pointer wrap is natural binary rollover. A full FIFO has the MSBs differing and the low bits equal.

## Timing
- Reset (reset_n low, asynchronous) sets:
  - `wr_ptr`, `rd_ptr`, `overflow` = 0
  - `count` = 0, `empty` = 1, `full` = 0, `almost_full` = 0, `out_valid` = 0
  - `in_ready` = 0 while reset is held
- Memory is not reset.
- Push to pop latency: a word pushed at edge N is on `out_data`, with `out_valid` high if `drain_en` is high, after edge N (one-cycle latency).
- `count`, `full`, `empty` and `almost_full` reflect a push or pop one cycle after the edge on which it occurs.
- `out_valid` follows `drain_en` combinationally in the same cycle.
- Reset asserted mid-transfer: any handshake in progress is lost with no partial write. The first accepted word after release lands at address 0.
- `clear` held for multiple cycles keeps the FIFO empty, but `in_ready` stays high. A push in a cycle where `clear` is high is discarded.

## Test plan
- Reset then fill: hold `drain_en`=0 and push 16 words 0x0001..0x0010 → `almost_full`=1 after the 14th, `full`=1 and `in_ready`=0 after the 16th, `count`=16.
- Overflow: with the FIFO full, assert `in_valid` for one cycle → `overflow`=1 and stays 1; pulse `clear` → `count`=0, `empty`=1, `overflow`=0.
- Drain window: with 16 words stored, raise `drain_en` for 16 cycles with `out_ready`=1 → `out_data` sequence 0x0001..0x0010, then `empty`=1 and `out_valid`=0.
- Streaming with wrap: `drain_en`=1, push and pop every cycle for 40 words after pre-loading 3 → `count` stays 3, data in order across pointer wrap.
- Full with pop: at `count`=16 assert `in_valid` and pop → next cycle `count`=15, pushed word not stored.
- Async reset mid-stream at `count`=7 → `count`=0, `empty`=1 immediately; the next push is read back correctly.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready write port and drain-window gated read port.
// Status flags are decoded from the registered write/read pointers only.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  drain_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Occupancy, flags and handshake qualifiers decoded from registered pointers
    always_comb begin
        w_count     = r_wr_ptr - r_rd_ptr;
        w_full      = (w_count == LP_DEPTH);
        w_empty     = (w_count == '0);
        in_ready    = !w_full && reset_n;
        out_valid   = !w_empty && drain_en;
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
        count       = w_count;
        full        = w_full;
        empty       = w_empty;
        almost_full = (w_count >= LP_AF);
        overflow    = r_overflow;
        out_data    = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end

    // Pointer and sticky overflow update; clear outranks push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage write; contents are never reset or cleared
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        drain_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        overflow;

    int checks;
    int errors;

    sync_fifo #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .AF_LEVEL   (14)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout sim time exceeded, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        drain_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fill();
        drain_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            @(negedge clk);
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
            checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, i >= 14); end
            checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 16); end
            checks++; if (in_ready !== (i < 16)) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, in_ready, i < 16); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_out_valid[%0d] got %b exp 0", i, out_valid); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", overflow); end
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        repeat (2) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_drain();
        drain_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_data !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, 16'(i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_ovf got %b exp 1", overflow); end
        drain_en  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_clear_hold();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (count !== 5'd0) begin errors++; $display("FAIL clr_count[%0d] got %0d exp 0", i, count); end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty[%0d] got %b exp 1", i, empty); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready[%0d] got %b exp 1", i, in_ready); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf[%0d] got %b exp 0", i, overflow); end
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL clr_after_count got %0d exp 0", count); end
    endtask

    task automatic test_full_pop();
        drain_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full got %b exp 1", full); end
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fp_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fp_out_valid got %b exp 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL fp_count got %0d exp 15", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fp_full_after got %b exp 0", full); end
        for (int i = 1; i < 16; i++) begin
            #1;
            checks++; if (out_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL fp_data[%0d] got %h exp %h", i, out_data, 16'h0100 + 16'(i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fp_empty got %b exp 1", empty); end
        drain_en  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
    endtask

    task automatic test_stream();
        drain_en  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h2000 + 16'(i);
            @(negedge clk);
        end
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL st_preload got %0d exp 3", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h2003 + 16'(k);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %b exp 1", k, out_valid); end
            checks++; if (out_data !== 16'h2000 + 16'(k)) begin errors++; $display("FAIL st_data[%0d] got %h exp %h", k, out_data, 16'h2000 + 16'(k)); end
            @(negedge clk);
            checks++; if (count !== 5'd3) begin errors++; $display("FAIL st_count[%0d] got %0d exp 3", k, count); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain_en  = 1'b0;
    endtask

    task automatic test_async_reset();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h3000 + 16'(i);
            @(negedge clk);
        end
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL ar_pre_count got %0d exp 7", count); end
        in_data = 16'hDEAD;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_empty got %b exp 1", empty); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready got %b exp 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        drain_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL ar_post_count got %0d exp 1", count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_post_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL ar_post_data got %h exp 1234", out_data); end
        drain_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_clear_hold();
        test_full_pop();
        test_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
